// File: rtl/bcd_calc_pkg.sv
// Shared constants, state type and 7-seg table for the BCD adder calculator.
// The seg decode in bcd_add_seq is enabled by defining BCD_ADD_SEQ_SEG_EN.
package bcd_calc_pkg;
  localparam int NDIG_DEFAULT = 4;

  localparam logic [3:0] KEY_PLUS = 4'hA;
  localparam logic [3:0] KEY_EQ   = 4'hB;
  localparam logic [3:0] KEY_CLR  = 4'hC;

  typedef enum logic [1:0] {
    ENTER_A,
    ENTER_B,
    ADD,
    DONE
  } state_e;

  // gfedcba, active-high
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    if (d > 4'd9) return 7'h00;
    return SEG_LUT[d];
  endfunction
endpackage

// File: rtl/bcd_add_seq_digit.sv
// One-digit BCD adder: binary add, then +6 correction when the sum exceeds 9.
// Purely combinational; shared by all digit positions of the sequencer.
module bcd_digit_add (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);
  logic [4:0] bin;
  logic [4:0] adj;

  assign bin  = {1'b0, a} + {1'b0, b} + {4'd0, cin};
  assign adj  = bin + 5'd6;
  assign cout = (bin > 5'd9);
  assign s    = cout ? adj[3:0] : bin[3:0];
endmodule

// File: rtl/bcd_add_seq.sv
// Keypad sequencer for an NDIG-digit BCD adder; digit-serial add, LSD first.
// Define BCD_ADD_SEQ_SEG_EN to register a 7-seg decode of disp_bcd onto seg.
module bcd_add_seq
  import bcd_calc_pkg::*;
#(
  parameter int NDIG = NDIG_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic              key_ready,
  output logic [4*NDIG-1:0] disp_bcd,
  output logic              ovf,
  output logic              busy,
  output logic              done,
  output logic [7*NDIG-1:0] seg
);
  localparam int W  = 4 * NDIG;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_e          st_q, st_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    s_q, s_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            c_q, c_d;
  logic            ovf_q, ovf_d;
  logic            done_q, done_d;

  logic            acc;
  logic            k_dig, k_plus, k_eq, k_clr;
  logic [3:0]      da, db, dsum;
  logic            dcout;

  assign acc    = key_valid && key_ready;
  assign k_dig  = (key_code <= 4'd9);
  assign k_plus = (key_code == KEY_PLUS);
  assign k_eq   = (key_code == KEY_EQ);
  assign k_clr  = (key_code == KEY_CLR);

  assign da = a_q[4*idx_q +: 4];
  assign db = b_q[4*idx_q +: 4];

  bcd_digit_add u_add (
    .a    (da),
    .b    (db),
    .cin  (c_q),
    .s    (dsum),
    .cout (dcout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= ENTER_A;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      idx_q  <= '0;
      c_q    <= 1'b0;
      ovf_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      a_q    <= a_d;
      b_q    <= b_d;
      s_q    <= s_d;
      idx_q  <= idx_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    a_d    = a_q;
    b_d    = b_q;
    s_d    = s_q;
    idx_d  = idx_q;
    c_d    = c_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    if (st_q == ADD) begin
      s_d[4*idx_q +: 4] = dsum;
      c_d   = dcout;
      idx_d = idx_q + 1'b1;
      if (idx_q == IW'(NDIG - 1)) begin
        ovf_d  = dcout;
        done_d = 1'b1;
        idx_d  = '0;
        st_d   = DONE;
      end
    end else if (acc) begin
      unique case (1'b1)
        k_clr: begin
          st_d  = ENTER_A;
          a_d   = '0;
          b_d   = '0;
          s_d   = '0;
          idx_d = '0;
          c_d   = 1'b0;
          ovf_d = 1'b0;
        end
        k_dig: begin
          if (st_q == ENTER_A) begin
            a_d = {a_q[W-5:0], key_code};
          end else if (st_q == ENTER_B) begin
            b_d = {b_q[W-5:0], key_code};
          end else begin
            a_d   = {{(W-4){1'b0}}, key_code};
            ovf_d = 1'b0;
            st_d  = ENTER_A;
          end
        end
        k_plus: begin
          if (st_q == ENTER_A) begin
            b_d  = '0;
            st_d = ENTER_B;
          end else if (st_q == DONE) begin
            // chaining: carry-out digit is dropped
            a_d   = s_q;
            b_d   = '0;
            ovf_d = 1'b0;
            st_d  = ENTER_B;
          end
        end
        k_eq: begin
          if (st_q == ENTER_B) begin
            s_d   = '0;
            idx_d = '0;
            c_d   = 1'b0;
            ovf_d = 1'b0;
            st_d  = ADD;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (st_q)
      ENTER_A: disp_bcd = a_q;
      ENTER_B: disp_bcd = b_q;
      default: disp_bcd = s_q;
    endcase
  end

  assign key_ready = (st_q != ADD);
  assign busy      = (st_q == ADD);
  assign done      = done_q;
  assign ovf       = ovf_q;

`ifdef BCD_ADD_SEQ_SEG_EN
  logic [7*NDIG-1:0] seg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q <= '0;
    end else begin
      for (int i = 0; i < NDIG; i++) begin
        seg_q[7*i +: 7] <= seg_of(disp_bcd[4*i +: 4]);
      end
    end
  end

  assign seg = seg_q;
`else
  assign seg = '0;
`endif
endmodule
